// File: rtl/univ_sh_reg_if.sv
// Command/data bundle for univ_sh_reg: the requester drives the command side
// and the register drives the result and status side.
interface univ_sh_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [WIDTH-1:0] Q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, din, sin,
    input  Q, sout, busy, done
  );

  modport slave (
    input  start, op, amt, din, sin,
    output Q, sout, busy, done
  );
endinterface

// File: rtl/univ_sh_reg.sv
// Universal shift register: parallel load plus shl/shr/rotl/rotr/asr, executed
// one bit per clock for a programmable step count, with busy/done signalling.
module univ_sh_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input logic           clk,
  input logic           reset,
  univ_sh_reg_if.slave  bus
);

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpShl  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpRotl = 3'b011;
  localparam logic [2:0] OpRotr = 3'b100;
  localparam logic [2:0] OpAsr  = 3'b101;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [AMT_W-1:0] r_cnt, w_cnt_d;
  logic [2:0]       r_op, w_op_d;
  logic [WIDTH-1:0] r_q, w_q_d, w_step_q;
  logic             r_sout, w_sout_d, w_step_sout;
  logic             r_done, w_done_d;
  logic             w_is_shift;

  // Single-bit step of the latched operation; sin is taken live on each step.
  always_comb begin
    w_step_q    = r_q;
    w_step_sout = r_sout;
    case (r_op)
      OpShl: begin
        w_step_q    = {r_q[WIDTH-2:0], bus.sin};
        w_step_sout = r_q[WIDTH-1];
      end
      OpShr: begin
        w_step_q    = {bus.sin, r_q[WIDTH-1:1]};
        w_step_sout = r_q[0];
      end
      OpRotl: begin
        w_step_q    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_step_sout = r_q[WIDTH-1];
      end
      OpRotr: begin
        w_step_q    = {r_q[0], r_q[WIDTH-1:1]};
        w_step_sout = r_q[0];
      end
      OpAsr: begin
        w_step_q    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_step_sout = r_q[0];
      end
      default: ;
    endcase
  end

  assign w_is_shift = (bus.op >= OpShl) && (bus.op <= OpAsr);

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_op_d    = r_op;
    w_q_d     = r_q;
    w_sout_d  = r_sout;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_op_d = bus.op;
          if (bus.op == OpLoad) begin
            w_q_d    = bus.din;
            w_done_d = 1'b1;
          end else if (w_is_shift && (bus.amt != '0)) begin
            w_cnt_d   = bus.amt;
            w_state_d = StRun;
          end else begin
            // Zero-step shift or reserved op completes immediately with no effect.
            w_done_d = 1'b1;
          end
        end
      end
      StRun: begin
        w_q_d    = w_step_q;
        w_sout_d = w_step_sout;
        w_cnt_d  = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_op    <= OpLoad;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_op    <= w_op_d;
      r_q     <= w_q_d;
      r_sout  <= w_sout_d;
      r_done  <= w_done_d;
    end
  end

  assign bus.Q    = r_q;
  assign bus.sout = r_sout;
  assign bus.busy = (r_state == StRun);
  assign bus.done = r_done;

endmodule

// File: tb/tb_univ_sh_reg.sv
// Bench for univ_sh_reg: arithmetic reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_univ_sh_reg;
  localparam int W = 8;
  localparam int A = 4;

  logic clk = 1'b0;
  logic reset;
  logic chk_on = 1'b0;
  logic rnd_sin = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  univ_sh_reg_if #(.WIDTH(W), .AMT_W(A)) bus ();

  univ_sh_reg #(.WIDTH(W), .AMT_W(A)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-step count plus arithmetic shifts on integers.
  logic [W-1:0] m_q;
  logic         m_sout;
  logic         m_done;
  int           m_left;
  int           m_op;

  always @(posedge clk) begin
    if (reset) begin
      m_q = '0; m_sout = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_left == 0) begin
      m_done = 1'b0;
      if (bus.start) begin
        if (bus.op == 3'd0) begin
          m_q = bus.din;
          m_done = 1'b1;
        end else if (bus.op <= 3'd5 && bus.amt != 0) begin
          m_left = int'(bus.amt);
          m_op   = int'(bus.op);
        end else begin
          m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      case (m_op)
        1: begin m_sout = m_q[W-1]; m_q = (m_q << 1) | W'(bus.sin); end
        2: begin m_sout = m_q[0];   m_q = (m_q >> 1) | (W'(bus.sin) << (W - 1)); end
        3: begin m_sout = m_q[W-1]; m_q = (m_q << 1) | (m_q >> (W - 1)); end
        4: begin m_sout = m_q[0];   m_q = (m_q >> 1) | (m_q << (W - 1)); end
        default: begin m_sout = m_q[0]; m_q = W'($signed(m_q) >>> 1); end
      endcase
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model.Q",    int'(bus.Q),    int'(m_q));
      check("model.sout", int'(bus.sout), int'(m_sout));
      check("model.busy", int'(bus.busy), int'(m_left != 0));
      check("model.done", int'(bus.done), int'(m_done));
    end
  end

  // Drive a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input int op, input int amt, input int din);
    bus.op    = 3'(op);
    bus.amt   = A'(amt);
    bus.din   = W'(din);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (rnd_sin) bus.sin = 1'($urandom);
      @(negedge clk);
    end
    if (!bus.done) check("done_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.amt = '0; bus.din = '0; bus.sin = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst.Q", int'(bus.Q), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.done", int'(bus.done), 0);
    check("rst.sout", int'(bus.sout), 0);
    reset = 1'b0;

    // Load
    issue(0, 0, 'hA5);
    check("load.Q", int'(bus.Q), 'hA5);
    check("load.done", int'(bus.done), 1);
    check("load.busy", int'(bus.busy), 0);
    check("load.sout", int'(bus.sout), 0);
    @(negedge clk);
    check("load.done_clr", int'(bus.done), 0);

    // shl by 1 with sin=1
    bus.sin = 1'b1;
    issue(1, 1, 0);
    check("shl.busy", int'(bus.busy), 1);
    @(negedge clk);
    check("shl.Q", int'(bus.Q), 'h4B);
    check("shl.sout", int'(bus.sout), 1);
    check("shl.done", int'(bus.done), 1);
    check("shl.busy_end", int'(bus.busy), 0);
    bus.sin = 1'b0;

    // rotr 3 from 0x81, then rotl 8 returns the same value
    issue(0, 0, 'h81);
    issue(4, 3, 0);
    check("rotr.busy0", int'(bus.busy), 1);
    @(negedge clk);
    check("rotr.Q1", int'(bus.Q), 'hC0);
    @(negedge clk);
    check("rotr.Q2", int'(bus.Q), 'h60);
    check("rotr.busy2", int'(bus.busy), 1);
    @(negedge clk);
    check("rotr.Q3", int'(bus.Q), 'h30);
    check("rotr.sout", int'(bus.sout), 0);
    check("rotr.done", int'(bus.done), 1);
    check("rotr.busy3", int'(bus.busy), 0);
    issue(3, 8, 0);
    wait_done();
    check("rotl8.Q", int'(bus.Q), 'h30);

    // asr
    issue(0, 0, 'h90);
    issue(5, 2, 0);
    wait_done();
    check("asr2.Q", int'(bus.Q), 'hE4);
    check("asr2.sout", int'(bus.sout), 0);
    issue(5, 15, 0);
    wait_done();
    check("asr15.Q", int'(bus.Q), 'hFF);

    // Reserved op: no effect, immediate done
    issue(6, 5, 'h12);
    check("rsv.done", int'(bus.done), 1);
    check("rsv.busy", int'(bus.busy), 0);
    check("rsv.Q", int'(bus.Q), 'hFF);

    // Start during RUN ignored; start held in the done cycle is accepted
    issue(0, 0, 'h01);
    bus.op = 3'd1; bus.amt = 4'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.op = 3'd0; bus.din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    bus.op = 3'd4; bus.amt = 4'd1;
    wait_done();
    check("arb.Q", int'(bus.Q), 'h10);
    @(negedge clk);
    bus.start = 1'b0;
    check("arb.busy_next", int'(bus.busy), 1);
    wait_done();
    check("arb.Q2", int'(bus.Q), 'h08);

    // Mixed commands with live random sin, checked by the model only
    rnd_sin = 1'b1;
    for (int k = 0; k < 8; k++) begin
      issue(int'($urandom_range(7, 0)), int'($urandom_range(11, 0)), int'($urandom_range(255, 0)));
      wait_done();
    end
    rnd_sin = 1'b0;

    // Reset mid-rotate, with start held alongside it
    issue(0, 0, 'h0F);
    issue(3, 8, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid.Q", int'(bus.Q), 'h78);
    reset = 1'b1;
    bus.op = 3'd0; bus.din = 8'hFF; bus.start = 1'b1;
    @(negedge clk);
    check("rstmid.Q", int'(bus.Q), 0);
    check("rstmid.busy", int'(bus.busy), 0);
    check("rstmid.sout", int'(bus.sout), 0);
    check("rstmid.done", int'(bus.done), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("post.done", int'(bus.done), 0);
    check("post.Q", int'(bus.Q), 0);
    check("post.busy", int'(bus.busy), 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
